// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter and sequencer for one shared memory
// port serving the instruction-fetch (IF) and data-memory (DM) requesters.
// A granted transfer holds mem_en for WAIT_CYC cycles, then pulses the
// owner's ack for one cycle. Every output is driven straight from a flop.

module mem_port_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant_dm
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // Counter preload: the last ACCESS cycle is the one where cnt reaches zero.
  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYC - 1);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                last_dm_q, last_dm_d;
  logic                grant_dm_q, grant_dm_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic                busy_q, busy_d;
  logic                if_ack_q, if_ack_d;
  logic                dm_ack_q, dm_ack_d;
  logic                pick_dm_s;

  // Next-state logic: arbitration, request latching, wait counting, read capture.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_dm_d  = last_dm_q;
    grant_dm_d = grant_dm_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    pick_dm_s  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (if_req || dm_req) begin
          // On a tie, the side that did not win last time gets the port.
          pick_dm_s  = dm_req && (!if_req || !last_dm_q);
          grant_dm_d = pick_dm_s;
          last_dm_d  = pick_dm_s;
          addr_d     = pick_dm_s ? dm_addr : if_addr;
          we_d       = pick_dm_s && dm_we;
          wdata_d    = pick_dm_s ? dm_wdata : {DATA_W{1'b0}};
          cnt_d      = CNT_LOAD;
          state_d    = ST_ACCESS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Last access cycle: memory data is valid, capture for the owner.
          if (!we_q) begin
            if (grant_dm_q) begin
              dm_rdata_d = mem_rdata;
            end else begin
              if_rdata_d = mem_rdata;
            end
          end else begin
            dm_rdata_d = dm_rdata_q;
          end
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Output flops are loaded from the next state so they line up with it.
    mem_en_d = (state_d == ST_ACCESS);
    mem_we_d = mem_en_d && we_d;
    busy_d   = (state_d != ST_IDLE);
    if_ack_d = (state_d == ST_RESP) && !grant_dm_d;
    dm_ack_d = (state_d == ST_RESP) && grant_dm_d;
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      last_dm_q  <= 1'b0;
      grant_dm_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= {ADDR_W{1'b0}};
      wdata_q    <= {DATA_W{1'b0}};
      if_rdata_q <= {DATA_W{1'b0}};
      dm_rdata_q <= {DATA_W{1'b0}};
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      busy_q     <= 1'b0;
      if_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_dm_q  <= last_dm_d;
      grant_dm_q <= grant_dm_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      busy_q     <= busy_d;
      if_ack_q   <= if_ack_d;
      dm_ack_q   <= dm_ack_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_ack    = if_ack_q;
  assign dm_ack    = dm_ack_q;
  assign busy      = busy_q;
  assign grant_dm  = grant_dm_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter with a scoreboard of expected
// completions (owner and read data) pushed at request time and popped on ack.

module tb_mem_port_arbiter;

  localparam int WAIT_CYC = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, dm_req, dm_we;
  logic [15:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [15:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_ack, dm_ack, mem_en, mem_we, busy, grant_dm;

  typedef struct packed {
    logic        dm;
    logic [15:0] rdata;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] m_if, m_dm;
  int          tests = 0;
  int          fails = 0;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYC(WAIT_CYC)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .grant_dm(grant_dm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic dm, input logic [15:0] rd);
    exp_t e;
    e.dm    = dm;
    e.rdata = rd;
    sb.push_back(e);
  endtask

  // Called in an ack cycle: compares owner and owner's rdata with the scoreboard.
  task automatic pop_check(input logic dm_seen);
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_unexpected_ack", 16'd1, 16'd0);
    end else begin
      e = sb.pop_front();
      chk("sb_owner", {15'd0, dm_seen}, {15'd0, e.dm});
      chk("sb_rdata", dm_seen ? dm_rdata : if_rdata, e.rdata);
    end
  endtask

  // One complete transfer from an idle DUT, checked cycle by cycle.
  task automatic xfer(input logic dm, input logic we, input logic [15:0] addr,
                      input logic [15:0] wd, input logic [15:0] rd);
    if (dm) begin
      dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wd;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    mem_rdata = rd;
    if (dm && !we) m_dm = rd;
    else if (!dm) m_if = rd;
    push_exp(dm, dm ? m_dm : m_if);
    @(negedge clk);
    if_req = 1'b0; dm_req = 1'b0;
    for (int c = 0; c < WAIT_CYC; c++) begin
      if (c > 0) @(negedge clk);
      chk("acc_mem_en", {15'd0, mem_en}, 16'd1);
      chk("acc_mem_we", {15'd0, mem_we}, {15'd0, dm & we});
      chk("acc_mem_addr", mem_addr, addr);
      chk("acc_mem_wdata", mem_wdata, dm ? wd : 16'h0000);
      chk("acc_busy", {15'd0, busy}, 16'd1);
      chk("acc_no_ack", {14'd0, if_ack, dm_ack}, 16'd0);
    end
    @(negedge clk);
    chk("resp_if_ack", {15'd0, if_ack}, {15'd0, ~dm});
    chk("resp_dm_ack", {15'd0, dm_ack}, {15'd0, dm});
    chk("resp_mem_en", {15'd0, mem_en}, 16'd0);
    chk("resp_busy", {15'd0, busy}, 16'd1);
    pop_check(dm_ack);
    @(negedge clk);
    chk("idle_busy", {15'd0, busy}, 16'd0);
    chk("idle_no_ack", {14'd0, if_ack, dm_ack}, 16'd0);
  endtask

  initial begin
    int   acks;
    int   last_ack_cyc;
    logic got;

    rst_n = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    if_addr = 16'h0; dm_addr = 16'h0; dm_wdata = 16'h0; mem_rdata = 16'h0;
    m_if = 16'h0; m_dm = 16'h0;
    #12;
    chk("rst_mem_en", {15'd0, mem_en}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_grant_dm", {15'd0, grant_dm}, 16'd0);
    chk("rst_if_rdata", if_rdata, 16'h0);
    chk("rst_dm_rdata", dm_rdata, 16'h0);
    chk("rst_mem_addr", mem_addr, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // IF read, DM read, DM write (rdata unchanged), IF read (dm_rdata kept).
    xfer(1'b0, 1'b0, 16'h0010, 16'h0000, 16'hA5A5);
    chk("if_rdata_a5a5", if_rdata, 16'hA5A5);
    xfer(1'b1, 1'b0, 16'h0080, 16'h0000, 16'hBEEF);
    xfer(1'b1, 1'b1, 16'h0100, 16'h1234, 16'hDEAD);
    chk("dm_rdata_after_write", dm_rdata, 16'hBEEF);
    xfer(1'b0, 1'b0, 16'h0040, 16'h0000, 16'h1111);
    chk("dm_rdata_after_if", dm_rdata, 16'hBEEF);
    chk("if_rdata_1111", if_rdata, 16'h1111);

    // IF holds req through ack; address change mid-access ignored.
    if_req = 1'b1; if_addr = 16'h0010; mem_rdata = 16'h3333; m_if = 16'h3333;
    push_exp(1'b0, 16'h3333);
    @(negedge clk);
    chk("hold_addr_c1", mem_addr, 16'h0010);
    if_addr = 16'h0020;
    @(negedge clk);
    chk("hold_addr_c2", mem_addr, 16'h0010);
    chk("hold_en_c2", {15'd0, mem_en}, 16'd1);
    @(negedge clk);
    chk("hold_ack1", {15'd0, if_ack}, 16'd1);
    pop_check(1'b0);
    mem_rdata = 16'h4444; m_if = 16'h4444;
    push_exp(1'b0, 16'h4444);
    @(negedge clk);
    chk("hold_idle_gap", {14'd0, busy, mem_en}, 16'd0);
    @(negedge clk);
    chk("hold_reissue_en", {15'd0, mem_en}, 16'd1);
    chk("hold_reissue_addr", mem_addr, 16'h0020);
    if_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("hold_ack2", {15'd0, if_ack}, 16'd1);
    pop_check(1'b0);
    @(negedge clk);

    // Reset in the first ACCESS cycle of a DM write.
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h0200; dm_wdata = 16'h7777;
    @(negedge clk);
    dm_req = 1'b0;
    chk("pre_rst_we", {15'd0, mem_we}, 16'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_en_we", {14'd0, mem_en, mem_we}, 16'd0);
    chk("rst_async_busy", {15'd0, busy}, 16'd0);
    m_if = 16'h0; m_dm = 16'h0;
    @(negedge clk);
    chk("rst_no_ack", {14'd0, if_ack, dm_ack}, 16'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_no_ack", {14'd0, if_ack, dm_ack}, 16'd0);
    xfer(1'b0, 1'b0, 16'h0300, 16'h0000, 16'h2222);

    // Tie after an IF grant goes to DM.
    dm_req = 1'b1; if_req = 1'b1; dm_we = 1'b0;
    dm_addr = 16'h0400; if_addr = 16'h0500; mem_rdata = 16'h6666; m_dm = 16'h6666;
    push_exp(1'b1, 16'h6666);
    @(negedge clk);
    chk("tie_grant_dm", {15'd0, grant_dm}, 16'd1);
    chk("tie_addr", mem_addr, 16'h0400);
    if_req = 1'b0; dm_req = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (if_ack || dm_ack) begin
        got = 1'b1;
        pop_check(dm_ack);
      end
    end
    chk("tie_ack_seen", {15'd0, got}, 16'd1);
    @(negedge clk);

    // Both requests held from reset: DM, IF, DM, IF at a 4-cycle ack period.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    dm_req = 1'b1; if_req = 1'b1; dm_we = 1'b0;
    dm_addr = 16'h0D00; if_addr = 16'h0A00; mem_rdata = 16'h5555;
    push_exp(1'b1, 16'h5555); push_exp(1'b0, 16'h5555);
    push_exp(1'b1, 16'h5555); push_exp(1'b0, 16'h5555);
    acks = 0; last_ack_cyc = 0;
    for (int c = 1; c <= 30 && acks < 4; c++) begin
      @(negedge clk);
      chk("rr_no_overlap", {15'd0, if_ack & dm_ack}, 16'd0);
      if (if_ack || dm_ack) begin
        acks++;
        chk("rr_ack_period", 16'(c - last_ack_cyc), (acks == 1) ? 16'd3 : 16'd4);
        last_ack_cyc = c;
        pop_check(dm_ack);
        if (acks == 4) begin
          dm_req = 1'b0; if_req = 1'b0;
        end
      end
    end
    dm_req = 1'b0; if_req = 1'b0;
    chk("rr_ack_count", 16'(acks), 16'd4);
    chk("sb_empty", 16'(sb.size()), 16'd0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer for a single shared 16-bit memory port, driven by two requesters: the instruction-fetch path (IM_Read side) and the data-memory path (DM_Read/DM_Wr side) of the multicycle RISC core. It grants one requester at a time and latches that requester's address, write enable and write data. It holds the memory strobes for a fixed number of wait cycles, then returns read data with a one-cycle acknowledge. Contention is resolved round-robin, so neither fetch nor data access can starve.

## Interface
Parameters:
- ADDR_W, 16, address width
- DATA_W, 16, data width
- WAIT_CYC, 2, memory access cycles per transfer (legal range 1..15)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch read request
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetch read data, registered
- if_ack  out  1  fetch completion pulse
- dm_req  in  1  data request
- dm_we  in  1  1 = write, 0 = read
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  data write value
- dm_rdata  out  DATA_W  data read data, registered
- dm_ack  out  1  data completion pulse
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid on the last mem_en cycle
- busy  out  1  high while state is not IDLE
- grant_dm  out  1  current/last owner: 1 = DM, 0 = IF

## Operation
- FSM has three states: IDLE, ACCESS and RESP.
- IDLE, on a clk edge:
  - Only one req high: grant that requester.
  - Both high: grant the requester not granted last (last_dm flag). After reset last_dm = 0, so the first tie goes to DM.
  - No request: remain in IDLE.
- On grant:
  - Latch addr; latch we (forced 0 for IF) and wdata (IF: 0).
  - Set grant_dm and last_dm; load cnt = WAIT_CYC-1; go to ACCESS.
- ACCESS:
  - Drive mem_en = 1 and mem_we, mem_addr, mem_wdata from the latches.
  - If cnt != 0, decrement cnt.
  - If cnt == 0 at the edge: for a read, capture mem_rdata into the owner's rdata register; go to RESP.
- RESP:
  - Owner's ack = 1 for exactly one cycle; mem_en = 0; next edge returns to IDLE.
- rdata registers hold their value until that requester's next read completes. Writes do not modify dm_rdata.
- Requests are not abortable:
  - req dropping during ACCESS does not stop the access, and ack still pulses.
  - Changes to addr/wdata/we after grant are ignored.
- Requester rule: deassert req no later than the edge ending the ack cycle. A req still high at the following IDLE edge is a new request.
- Reset (rst_n low, any state, asynchronous):
  - Return to IDLE.
  - All outputs 0: mem_en, mem_we, mem_addr, mem_wdata, if_ack, dm_ack, if_rdata, dm_rdata, busy, grant_dm.
  - last_dm = 0, cnt = 0.
  - An in-flight access is discarded with no ack.
- All outputs are registered or decoded from state registers only. There is no combinational path from req to mem_* or ack.

## Timing
- req seen high at IDLE edge E0.
  - mem_en high in cycles E0+1 .. E0+WAIT_CYC.
  - ack high in cycle E0+WAIT_CYC+1.
  - Back in IDLE at E0+WAIT_CYC+2.
- Minimum issue period is WAIT_CYC+2 cycles, i.e. 4 at the default.
- busy is high from E0+1 through the ack cycle inclusive.
- if_ack and dm_ack are never high simultaneously. Exactly one ack follows each grant.
- rdata is valid in the ack cycle and stays stable afterward.
- WAIT_CYC=1: mem_en is high for one cycle and ack follows in the next cycle.

## Test plan
- IF read, addr 0x0010, mem_rdata=0xA5A5, WAIT_CYC=2 -> mem_en high for 2 cycles with mem_addr=0x0010, mem_we=0; if_ack pulses in the 3rd cycle after grant; if_rdata=0xA5A5; dm_ack stays 0.
- DM write, addr 0x0100, wdata 0x1234 -> mem_we=1 and mem_wdata=0x1234 for 2 cycles; dm_ack pulses once; dm_rdata unchanged from its previous value.
- Both reqs held continuously from reset for 4 transfers -> grant order DM, IF, DM, IF; ack period 4 cycles; acks never overlap.
- IF holds req through the ack -> a second access issues after exactly one IDLE cycle. Separately, change if_addr from 0x0010 to 0x0020 mid-ACCESS -> mem_addr stays 0x0010.
- Assert rst_n low in the first ACCESS cycle of a DM write -> mem_en/mem_we drop immediately, no dm_ack, busy=0. After release, an IF-only request is served normally; a tie then grants DM.
- DM read of 0xBEEF, then IF read of 0x1111 -> dm_rdata still 0xBEEF after the IF transfer completes.
